// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared state encoding, grant ids and default widths for the code ROM arbiter
package rom_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int MAX_FETCH_BYTES = 3;
  typedef enum logic [1:0] {IDLE, FETCH, MOVC, RESP} state_t;
  typedef enum logic {GNT_FETCH, GNT_MOVC} grant_t;
endpackage

// File: rtl/rom_rr_arb2.sv
// rom_rr_arb2: two-input round-robin grant; last_grant only moves when both requesters tie
module rom_rr_arb2
  import rom_ctrl_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   en,
  input  logic   fetch_req,
  input  logic   movc_req,
  output logic   grant_valid,
  output grant_t grant
);
  grant_t last_grant;
  logic tie;
  always_comb begin
    tie = fetch_req && movc_req;
    grant_valid = en && (fetch_req || movc_req);
    grant = tie ? (last_grant == GNT_FETCH ? GNT_MOVC : GNT_FETCH) : (movc_req ? GNT_MOVC : GNT_FETCH);
  end
  always_ff @(posedge clock) begin
    if (!reset) last_grant <= GNT_FETCH;
    else if (en && tie) last_grant <= grant;
  end
endmodule

// File: rtl/code_rom_arbiter.sv
// code_rom_arbiter: shares the program ROM between instruction fetch (1-3 bytes) and MOVC reads
module code_rom_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  fetch_req,
  input  logic [ADDR_WIDTH-1:0]                 fetch_pc,
  input  logic [1:0]                            fetch_len,
  output logic                                  fetch_valid,
  output logic [MAX_FETCH_BYTES*DATA_WIDTH-1:0] fetch_data,
  input  logic                                  movc_req,
  input  logic [ADDR_WIDTH-1:0]                 movc_addr,
  output logic                                  movc_valid,
  output logic [DATA_WIDTH-1:0]                 movc_data,
  output logic [ADDR_WIDTH-1:0]                 rom_addr,
  input  logic [DATA_WIDTH-1:0]                 rom_data,
  output logic                                  busy
);
  state_t state, state_nxt;
  grant_t grant;
  logic grant_valid, take, active, primed, last_cap;
  logic [1:0] issue, cap, len;
  logic [ADDR_WIDTH-1:0] base;
  rom_rr_arb2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .en         (state == IDLE),
    .fetch_req  (fetch_req),
    .movc_req   (movc_req),
    .grant_valid(grant_valid),
    .grant      (grant)
  );
  assign take = state == IDLE && grant_valid;
  assign active = state == FETCH || state == MOVC;
  // ROM output lags its address by one edge, so captures start on the second edge after grant
  assign last_cap = primed && cap == len - 2'd1;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = grant_valid ? (grant == GNT_MOVC ? MOVC : FETCH) : IDLE;
    else if (state == RESP) state_nxt = IDLE;
    else state_nxt = last_cap ? RESP : state;
  end
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      rom_addr <= '0;
      base <= '0;
      issue <= '0;
      cap <= '0;
      len <= '0;
      primed <= 1'b0;
      fetch_data <= '0;
      movc_data <= '0;
      fetch_valid <= 1'b0;
      movc_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      movc_valid <= 1'b0;
      if (take) begin
        base <= grant == GNT_MOVC ? movc_addr : fetch_pc;
        rom_addr <= grant == GNT_MOVC ? movc_addr : fetch_pc;
        len <= grant == GNT_MOVC ? 2'd1 : (fetch_len == 2'd0 ? 2'd1 : fetch_len);
        issue <= 2'd1;
        cap <= 2'd0;
        primed <= 1'b0;
        if (grant == GNT_FETCH) fetch_data <= '0;
      end
      if (active) begin
        primed <= 1'b1;
        if (issue < len) begin
          rom_addr <= base + ADDR_WIDTH'(issue);
          issue <= issue + 2'd1;
        end
        if (primed) begin
          cap <= cap + 2'd1;
          if (state == MOVC) movc_data <= rom_data;
          else fetch_data[cap*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
          if (last_cap) begin
            fetch_valid <= state == FETCH;
            movc_valid <= state == MOVC;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_code_rom_arbiter.sv
// tb_code_rom_arbiter: randomized and directed checks of the code ROM arbiter against a ROM array model
module tb_code_rom_arbiter;
  logic clock = 0, reset = 0, fetch_req = 0, movc_req = 0;
  logic [15:0] fetch_pc = '0, movc_addr = '0, rom_addr;
  logic [1:0] fetch_len = '0;
  logic fetch_valid, movc_valid, busy;
  logic [23:0] fetch_data;
  logic [7:0] movc_data, rom_data;
  logic [7:0] mem [0:65535];
  logic [15:0] addr_log [$];
  int checks = 0, errors = 0;

  code_rom_arbiter dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_len(fetch_len),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .movc_req(movc_req), .movc_addr(movc_addr),
    .movc_valid(movc_valid), .movc_data(movc_data), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) rom_data <= mem[rom_addr];

  function automatic logic [23:0] exp_fetch(input logic [15:0] pc, input logic [1:0] len);
    int n = (len == 0) ? 1 : int'(len);
    logic [23:0] r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = mem[pc + 16'(k)];
    return r;
  endfunction

  task automatic wait_idle();
    @(negedge clock);
    for (int i = 0; i < 10 && busy; i++) @(negedge clock);
  endtask

  task automatic run_fetch(input logic [15:0] pc, input logic [1:0] len, output logic [23:0] data, output int lat);
    wait_idle();
    fetch_pc = pc; fetch_len = len; fetch_req = 1; lat = -1;
    addr_log.delete();
    for (int i = 0; i <= 20; i++) begin
      @(posedge clock); #1;
      addr_log.push_back(rom_addr);
      if (fetch_valid) begin lat = i; break; end
    end
    data = fetch_data; fetch_req = 0;
  endtask

  task automatic run_movc(input logic [15:0] a, output logic [7:0] data, output int lat);
    wait_idle();
    movc_addr = a; movc_req = 1; lat = -1;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clock); #1;
      if (movc_valid) begin lat = i; break; end
    end
    data = movc_data; movc_req = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 0;
    @(negedge clock); reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks += 6;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
    if (movc_valid !== 1'b0) begin errors++; $display("FAIL reset_movc_valid got %b want 0", movc_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (rom_addr !== 16'h0) begin errors++; $display("FAIL reset_rom_addr got %h want 0000", rom_addr); end
    if (fetch_data !== 24'h0) begin errors++; $display("FAIL reset_fetch_data got %h want 000000", fetch_data); end
    if (movc_data !== 8'h0) begin errors++; $display("FAIL reset_movc_data got %h want 00", movc_data); end
    reset = 1;
  endtask

  task automatic test_fetch3();
    logic [23:0] d; int lat;
    run_fetch(16'h0100, 2'd3, d, lat);
    checks += 5;
    if (d !== 24'hAA9075) begin errors++; $display("FAIL fetch3_data got %h want aa9075", d); end
    if (lat !== 4) begin errors++; $display("FAIL fetch3_latency got %0d want 4", lat); end
    for (int k = 0; k < 3; k++)
      if (addr_log.size() <= k || addr_log[k] !== 16'h0100 + 16'(k)) begin
        errors++; $display("FAIL fetch3_rom_addr%0d got %h want %h", k, addr_log.size() > k ? addr_log[k] : 16'hxxxx, 16'h0100 + 16'(k));
      end
  endtask

  task automatic test_fetch1();
    logic [23:0] d; int lat;
    for (int l = 1; l >= 0; l--) begin
      run_fetch(16'h0200, 2'(l), d, lat);
      checks += 2;
      if (d !== 24'h0000E4) begin errors++; $display("FAIL fetch1_len%0d_data got %h want 0000e4", l, d); end
      if (lat !== 2) begin errors++; $display("FAIL fetch1_len%0d_latency got %0d want 2", l, lat); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] d; int lat;
    run_fetch(16'hFFFF, 2'd2, d, lat);
    checks += 4;
    if (d !== 24'h003412) begin errors++; $display("FAIL wrap_data got %h want 003412", d); end
    if (lat !== 3) begin errors++; $display("FAIL wrap_latency got %0d want 3", lat); end
    if (addr_log.size() < 2 || addr_log[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got %h want ffff", addr_log.size() > 0 ? addr_log[0] : 16'hxxxx); end
    if (addr_log.size() < 2 || addr_log[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got %h want 0000", addr_log.size() > 1 ? addr_log[1] : 16'hxxxx); end
  endtask

  task automatic tie_round(input int exp_first);
    int first = -1;
    bit seen_f = 0, seen_m = 0;
    logic [23:0] fd = '0;
    logic [7:0] md = '0;
    wait_idle();
    fetch_pc = 16'h0100; fetch_len = 2'd3; movc_addr = 16'h0300;
    fetch_req = 1; movc_req = 1;
    for (int i = 0; i < 40 && !(seen_f && seen_m); i++) begin
      @(posedge clock); #1;
      if (movc_valid) begin if (first < 0) first = 1; seen_m = 1; md = movc_data; movc_req = 0; end
      if (fetch_valid) begin if (first < 0) first = 0; seen_f = 1; fd = fetch_data; fetch_req = 0; end
    end
    fetch_req = 0; movc_req = 0;
    checks += 3;
    if (first !== exp_first) begin errors++; $display("FAIL tie_order got %0d want %0d (1=movc first)", first, exp_first); end
    if (md !== 8'h5A) begin errors++; $display("FAIL tie_movc_data got %h want 5a", md); end
    if (fd !== 24'hAA9075) begin errors++; $display("FAIL tie_fetch_data got %h want aa9075", fd); end
  endtask

  task automatic test_tie();
    pulse_reset();
    tie_round(1);
    tie_round(0);
  endtask

  task automatic test_reset_mid();
    logic [23:0] d; int lat, stray = 0;
    wait_idle();
    fetch_pc = 16'h0100; fetch_len = 2'd3; fetch_req = 1;
    @(posedge clock);
    @(negedge clock); reset = 0; fetch_req = 0;
    @(posedge clock); #1;
    checks += 5;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL midrst_fetch_valid got %b want 0", fetch_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (rom_addr !== 16'h0) begin errors++; $display("FAIL midrst_rom_addr got %h want 0000", rom_addr); end
    if (fetch_data !== 24'h0) begin errors++; $display("FAIL midrst_fetch_data got %h want 000000", fetch_data); end
    if (movc_data !== 8'h0) begin errors++; $display("FAIL midrst_movc_data got %h want 00", movc_data); end
    @(negedge clock); reset = 1;
    repeat (8) begin @(posedge clock); #1; if (fetch_valid || busy) stray++; end
    run_fetch(16'h0100, 2'd3, d, lat);
    checks += 3;
    if (stray !== 0) begin errors++; $display("FAIL midrst_stray_activity got %0d want 0", stray); end
    if (d !== 24'hAA9075) begin errors++; $display("FAIL midrst_refetch_data got %h want aa9075", d); end
    if (lat !== 4) begin errors++; $display("FAIL midrst_refetch_latency got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    int t[2] = '{-1, -1};
    logic [23:0] d[2] = '{24'h0, 24'h0};
    int n = 0;
    logic [23:0] exp = exp_fetch(16'h0200, 2'd2);
    wait_idle();
    fetch_pc = 16'h0200; fetch_len = 2'd2; fetch_req = 1;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(posedge clock); #1;
      if (fetch_valid) begin t[n] = i; d[n] = fetch_data; n++; end
    end
    fetch_req = 0;
    checks += 4;
    if (t[0] !== 3) begin errors++; $display("FAIL hold_first_latency got %0d want 3", t[0]); end
    if (t[1] - t[0] !== 5) begin errors++; $display("FAIL hold_gap got %0d want 5", t[1] - t[0]); end
    if (d[0] !== exp) begin errors++; $display("FAIL hold_data0 got %h want %h", d[0], exp); end
    if (d[1] !== exp) begin errors++; $display("FAIL hold_data1 got %h want %h", d[1], exp); end
  endtask

  task automatic test_random();
    logic [23:0] d; logic [7:0] m; int lat;
    for (int n = 0; n < 30; n++) begin
      logic [15:0] a = 16'($urandom);
      logic [1:0] l = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        run_fetch(a, l, d, lat);
        checks += 2;
        if (d !== exp_fetch(a, l)) begin errors++; $display("FAIL rand_fetch_data pc=%h len=%0d got %h want %h", a, l, d, exp_fetch(a, l)); end
        if (lat !== ((l == 0) ? 2 : int'(l) + 1)) begin errors++; $display("FAIL rand_fetch_latency len=%0d got %0d", l, lat); end
      end else begin
        run_movc(a, m, lat);
        checks += 2;
        if (m !== mem[a]) begin errors++; $display("FAIL rand_movc_data addr=%h got %h want %h", a, m, mem[a]); end
        if (lat !== 2) begin errors++; $display("FAIL rand_movc_latency got %0d want 2", lat); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'h75; mem[16'h0101] = 8'h90; mem[16'h0102] = 8'hAA;
    mem[16'h0200] = 8'hE4; mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    mem[16'h0300] = 8'h5A;
    test_reset();
    test_fetch3();
    test_fetch1();
    test_wrap();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
